alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit clocked ALU.
- Accepts one operation per transaction on a valid/ready input and returns result plus flags on a valid/ready output.
- Holds an internal flag register that feeds ADC/SBB.
- Multi-bit shifts/rotates run iteratively, one bit per cycle, under an FSM.
- Sits between the register-file read stage and writeback in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  {grp, opcode[2:0]}; encodings in alu_seq_pkg.
- a  in  WIDTH  first operand; shift/rotate source.
- b  in  WIDTH  second operand; shift amount in low SHAMT_W bits.
- flags_wr  in  1  load flags_in into flag register (IDLE only).
- flags_in  in  4  value for flags_wr.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- flags  out  4  flag register: [0] C carry, [1] B borrow, [2] Z zero, [3] P (XOR-reduce of result).
- out_err  out  1  accepted op was illegal; qualified by out_valid.

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE; in_ready = 1 (combinational from state).
  - out_valid = 0, result = 0, flags = 0, out_err = 0, shift counter = 0.
- FSM states are IDLE, SHIFT and DONE.
- Handshake and state rules:
  - in_ready = (state == IDLE).
  - Accept when in_valid & in_ready. Operands and op are latched at accept and are not sampled again.
  - IDLE to DONE on accept of a single-cycle op, or of a shift/rotate with amount 0. Result is registered at the accept edge, so latency is 1 cycle.
  - IDLE to SHIFT on accept of a shift/rotate with amount n > 0. Each SHIFT cycle moves the working register 1 bit and decrements the counter. On the edge where the counter reaches 0, go to DONE. Latency is 1 + n cycles.
  - DONE: out_valid = 1. result, flags and out_err are held stable until out_valid & out_ready, then go to IDLE. There is no back-to-back accept in the same cycle.
- Arithmetic ops (grp = 0), computed at WIDTH+1 bits:
  - ADD: C = carry out, B = 0.
  - ADC: a + b + flags[0]; C = carry out, B = 0.
  - SUB: a - b; B = (b > a), C = 0.
  - SBB: a - b - flags[1]; B = (b > a) | ((b == a) & flags[1]), C = 0.
  - XOR (3'b100): C and B unchanged.
  - Z and P are updated on all arithmetic ops.
- Logic/shift ops (grp = 1):
  - AND, OR, ROR, ROL, SHR (zero fill), SHL, SAR (sign fill) on encodings 0 to 6.
  - Shift/rotate amount n = b[SHAMT_W-1:0].
  - For SHR/SHL/SAR, C = last bit shifted out (unchanged if n = 0).
  - For ROR/ROL, C = the bit that wrapped on the final step.
  - Z and P are updated; B is unchanged.
- Illegal encodings (arith 5 to 7, logic 7):
  - Complete in 1 cycle with result = 0, flags unchanged, out_err = 1.
- Flag-register writes:
  - flags_wr is honoured only in IDLE and takes priority over a same-cycle accept. The accepted op then uses flags_in as its carry/borrow input.
  - flags_wr outside IDLE is ignored.
- rst_n asserted mid-SHIFT or mid-DONE: the operation is abandoned and outputs return to reset values immediately.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Arithmetic encoding 3'b101 = MUL, an unsigned iterative shift-add multiply that reuses the SHIFT state and counter.
  - Fixed WIDTH iterations; latency 1 + WIDTH cycles.
  - result = low WIDTH bits; C = |high half; B unchanged; Z and P from the low half.
- Undefined: 3'b101 is illegal (out_err = 1).

Decomposition:
- alu_seq_pkg holds:
  - op encodings as localparams/enum: OP_ADD .. OP_SAR, OP_MUL.
  - flag bit indices: FLG_C = 0, FLG_B = 1, FLG_Z = 2, FLG_P = 3.
  - FSM state typedef.
- One natural sub-module, alu_seq_shifter: a 1-bit-per-step shift/rotate/shift-add datapath with a registered working value and C output, driven by step/mode from the FSM.

Test Plan:
- ADD, WIDTH = 8: a = 8'hF0, b = 8'h20 -> result 8'h10, C = 1, Z = 0, P = 1; out_valid 1 cycle after accept.
- SUB then SBB: SUB a = 8'h05, b = 8'h05 -> result 0, Z = 1, B = 0. Then flags_wr flags_in = 4'b0010, SBB a = 8'h05, b = 8'h05 -> result 8'hFF, B = 1, P = 0.
- SHL, a = 8'h81, b = 3: exactly 3 cycles in SHIFT, out_valid on cycle 4 -> result 8'h08, C = 0. SAR a = 8'h80, b = 7 -> 8'hFF, C = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> result/flags stable, in_ready = 0, new in_valid not accepted. Release -> IDLE next cycle.
- Illegal op = 4'b0111 -> 1-cycle latency, out_err = 1, result 0, flags unchanged.
- Reset mid-SHIFT: rst_n low during ROR of 7 -> out_valid = 0, flags = 0 immediately, in_ready = 1 after release.
- With ALU_MUL_EN: MUL 8'h10 x 8'h11 -> result 8'h10, C = 1, latency 9.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings, flag indices and state/mode types for the sequential ALU.
// Optional MUL support is enabled by defining ALU_MUL_EN.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBB = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_ROR = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SAR = 4'hE;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_B = 1;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_P = 3;

`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [2:0] {SM_ROR, SM_ROL, SM_SHR, SM_SHL, SM_SAR, SM_MUL} sh_mode_e;

  function automatic sh_mode_e op_mode(input logic [3:0] op);
    case (op)
      OP_ROL:  return SM_ROL;
      OP_SHR:  return SM_SHR;
      OP_SHL:  return SM_SHL;
      OP_SAR:  return SM_SAR;
      OP_MUL:  return SM_MUL;
      default: return SM_ROR;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU; master drives requests, slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flags_wr;
  logic [3:0]       flags_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             out_err;

  modport master (
    output in_valid, op, a, b, flags_wr, flags_in, out_ready,
    input  in_ready, out_valid, result, flags, out_err
  );

  modport slave (
    input  in_valid, op, a, b, flags_wr, flags_in, out_ready,
    output in_ready, out_valid, result, flags, out_err
  );
endinterface

// File: rtl/alu_seq_shifter.sv
// One-bit-per-step shift/rotate and shift-add multiply datapath.
// work_step/hi_step/c_step are the values the registers take on the next step.
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             step,
  input  sh_mode_e         mode,
  output logic [WIDTH-1:0] work_step,
  output logic [WIDTH-1:0] hi_step,
  output logic             c_step
);
  logic [WIDTH-1:0] work_d, work_q;
  logic [WIDTH-1:0] hi_d, hi_q;
  logic [WIDTH-1:0] mcand_d, mcand_q;
  logic [WIDTH:0]   psum;

  always_comb begin
    work_step = work_q;
    hi_step   = hi_q;
    c_step    = 1'b0;
    psum      = '0;
    case (mode)
      SM_ROR: begin work_step = {work_q[0], work_q[WIDTH-1:1]};       c_step = work_q[0];       end
      SM_ROL: begin work_step = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; c_step = work_q[WIDTH-1]; end
      SM_SHR: begin work_step = {1'b0, work_q[WIDTH-1:1]};            c_step = work_q[0];       end
      SM_SHL: begin work_step = {work_q[WIDTH-2:0], 1'b0};            c_step = work_q[WIDTH-1]; end
      SM_SAR: begin work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; c_step = work_q[0];       end
      SM_MUL: begin
        // {hi, work} is the partial product; work's LSB selects the add, then both shift right.
        psum      = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
        hi_step   = psum[WIDTH:1];
        work_step = {psum[0], work_q[WIDTH-1:1]};
      end
      default: ;
    endcase

    work_d  = work_q;
    hi_d    = hi_q;
    mcand_d = mcand_q;
    if (load) begin
      work_d  = load_a;
      hi_d    = '0;
      mcand_d = load_b;
    end else if (step) begin
      work_d = work_step;
      hi_d   = hi_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      hi_q    <= '0;
      mcand_q <= '0;
    end else begin
      work_q  <= work_d;
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with flag register and iterative shifts (and MUL when
// ALU_MUL_EN is defined; otherwise that encoding reports an error).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int unsigned CNT_W = SHAMT_W + 1;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  sh_mode_e         mode_d, mode_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flags_d, flags_q;
  logic             err_d, err_q;

  logic             accept, sh_load, sh_step, c_step, cin, bin;
  logic [WIDTH-1:0] work_step, hi_step;
  logic [3:0]       fl_base;
  logic [WIDTH:0]   sum, diff;
  logic [SHAMT_W-1:0] shamt;
  logic             fin, fin_err, fin_c, fin_b;
  logic [WIDTH-1:0] fin_res;

  alu_seq_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_a    (bus.a),
    .load_b    (bus.b),
    .step      (sh_step),
    .mode      (mode_q),
    .work_step (work_step),
    .hi_step   (hi_step),
    .c_step    (c_step)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_err   = err_q;

  always_comb begin
    accept  = bus.in_valid && (state_q == IDLE);
    // A same-cycle flag write is visible to the op accepted in that cycle.
    fl_base = ((state_q == IDLE) && bus.flags_wr) ? bus.flags_in : flags_q;
    shamt   = bus.b[SHAMT_W-1:0];
    cin     = (bus.op == OP_ADC) && fl_base[FLG_C];
    bin     = (bus.op == OP_SBB) && fl_base[FLG_B];
    sum     = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    diff    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bin};

    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = fl_base;
    err_d       = err_q;
    sh_load     = 1'b0;
    sh_step     = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_res     = '0;
    fin_c       = fl_base[FLG_C];
    fin_b       = fl_base[FLG_B];

    case (state_q)
      IDLE: if (accept) begin
        sh_load = 1'b1;
        mode_d  = op_mode(bus.op);
        case (bus.op)
          OP_ADD, OP_ADC: begin fin = 1'b1; fin_res = sum[WIDTH-1:0];  fin_c = sum[WIDTH]; fin_b = 1'b0; end
          OP_SUB, OP_SBB: begin fin = 1'b1; fin_res = diff[WIDTH-1:0]; fin_c = 1'b0; fin_b = diff[WIDTH]; end
          OP_XOR: begin fin = 1'b1; fin_res = bus.a ^ bus.b; end
          OP_AND: begin fin = 1'b1; fin_res = bus.a & bus.b; end
          OP_OR:  begin fin = 1'b1; fin_res = bus.a | bus.b; end
          OP_ROR, OP_ROL, OP_SHR, OP_SHL, OP_SAR: begin
            if (shamt == '0) begin
              fin     = 1'b1;
              fin_res = bus.a;
            end else begin
              state_d = SHIFT;
              cnt_d   = CNT_W'(shamt);
            end
          end
          OP_MUL: begin
            if (MUL_EN) begin
              state_d = SHIFT;
              cnt_d   = CNT_W'(WIDTH);
            end else begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          end
          default: begin fin = 1'b1; fin_err = 1'b1; end
        endcase
      end
      SHIFT: begin
        sh_step = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          fin     = 1'b1;
          fin_res = work_step;
          fin_c   = (mode_q == SM_MUL) ? |hi_step : c_step;
        end
      end
      DONE: if (bus.out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      err_d       = fin_err;
      result_d    = fin_err ? '0 : fin_res;
      if (!fin_err) begin
        flags_d[FLG_C] = fin_c;
        flags_d[FLG_B] = fin_b;
        flags_d[FLG_Z] = (fin_res == '0);
        flags_d[FLG_P] = ^fin_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= SM_ROR;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH = 8) against a behavioural model of the ALU.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] tb_flags = 4'h0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                                input logic [3:0] fl_in, output logic [7:0] r, output logic [3:0] f,
                                output logic e, output int lat);
    int unsigned av, bv, n, full;
    logic signed [7:0] sa;
    logic c, bw;
    av = a_i; bv = b_i; n = b_i % 8; sa = a_i;
    c = fl_in[0]; bw = fl_in[1]; e = 1'b0; lat = 1; r = 8'h00; full = 0;
    case (op_i)
      4'd0: begin full = av + bv; r = full[7:0]; c = full > 255; bw = 1'b0; end
      4'd1: begin full = av + bv + (c ? 1 : 0); r = full[7:0]; c = full > 255; bw = 1'b0; end
      4'd2: begin r = 8'(av - bv); bw = bv > av; c = 1'b0; end
      4'd3: begin r = 8'(av - bv - (bw ? 1 : 0)); bw = (bv > av) || ((bv == av) && bw); c = 1'b0; end
      4'd4: r = a_i ^ b_i;
      4'd5: begin
`ifdef ALU_MUL_EN
        full = av * bv; r = full[7:0]; c = full[15:8] != 0; lat = 9;
`else
        e = 1'b1;
`endif
      end
      4'd8: r = a_i & b_i;
      4'd9: r = a_i | b_i;
      4'd10: begin r = a_i; if (n > 0) begin r = 8'((av >> n) | (av << (8 - n))); c = r[7]; lat = 1 + n; end end
      4'd11: begin r = a_i; if (n > 0) begin r = 8'((av << n) | (av >> (8 - n))); c = r[0]; lat = 1 + n; end end
      4'd12: begin r = a_i; if (n > 0) begin r = 8'(av >> n); c = ((av >> (n - 1)) & 1) != 0; lat = 1 + n; end end
      4'd13: begin r = a_i; if (n > 0) begin r = 8'(av << n); c = ((av >> (8 - n)) & 1) != 0; lat = 1 + n; end end
      4'd14: begin r = a_i; if (n > 0) begin r = sa >>> n; c = ((av >> (n - 1)) & 1) != 0; lat = 1 + n; end end
      default: e = 1'b1;
    endcase
    if (e) begin
      r = 8'h00;
      f = fl_in;
    end else begin
      f = {^r, r == 8'h00, bw, c};
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string nm, input logic [3:0] op_i, input logic [7:0] a_i,
                        input logic [7:0] b_i, input logic fw, input logic [3:0] fi);
    logic [7:0] er;
    logic [3:0] ef;
    logic ee;
    int elat, lat;
    model(op_i, a_i, b_i, fw ? fi : tb_flags, er, ef, ee, elat);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready before accept: got %b exp 1", nm, bus.in_ready);
    end
    bus.op = op_i; bus.a = a_i; bus.b = b_i; bus.flags_wr = fw; bus.flags_in = fi;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flags_wr = 1'b0;
    bus.a = ~a_i; bus.b = ~b_i; bus.op = ~op_i;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency: got %0d exp %0d", nm, lat, elat);
    end
    checks++;
    if (bus.result !== er) begin
      errors++; $display("FAIL %s result: got %h exp %h (op %h a %h b %h)", nm, bus.result, er, op_i, a_i, b_i);
    end
    checks++;
    if (bus.flags !== ef) begin
      errors++; $display("FAIL %s flags: got %b exp %b (op %h a %h b %h)", nm, bus.flags, ef, op_i, a_i, b_i);
    end
    checks++;
    if (bus.out_err !== ee) begin
      errors++; $display("FAIL %s out_err: got %b exp %b", nm, bus.out_err, ee);
    end
    tb_flags = ef;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: got valid %b ready %b exp 0 1", nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h00 ||
        bus.flags !== 4'h0 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy %b vld %b res %h flg %b err %b exp 1 0 00 0000 0",
               bus.in_ready, bus.out_valid, bus.result, bus.flags, bus.out_err);
    end
  endtask

  task automatic test_arith();
    run_op("add", 4'h0, 8'hF0, 8'h20, 1'b1, 4'h0);
    run_op("sub", 4'h2, 8'h05, 8'h05, 1'b0, 4'h0);
    run_op("sbb", 4'h3, 8'h05, 8'h05, 1'b1, 4'b0010);
    checks++;
    if (tb_flags !== 4'b0010) begin
      errors++; $display("FAIL sbb model flags: got %b exp 0010", tb_flags);
    end
    run_op("adc", 4'h1, 8'hFF, 8'h00, 1'b1, 4'b0001);
    run_op("xor", 4'h4, 8'h5A, 8'h5A, 1'b0, 4'h0);
  endtask

  task automatic test_shift();
    run_op("shl3", 4'hD, 8'h81, 8'h03, 1'b0, 4'h0);
    run_op("sar7", 4'hE, 8'h80, 8'h07, 1'b0, 4'h0);
    run_op("ror0", 4'hA, 8'h3C, 8'h08, 1'b1, 4'b0001);
    run_op("rol1", 4'hB, 8'h80, 8'h01, 1'b0, 4'h0);
    run_op("shr7", 4'hC, 8'hC1, 8'h07, 1'b0, 4'h0);
  endtask

  task automatic test_illegal();
    run_op("ill7", 4'h7, 8'h12, 8'h34, 1'b1, 4'b1011);
    run_op("illF", 4'hF, 8'hFF, 8'hFF, 1'b0, 4'h0);
    run_op("ill5", 4'h5, 8'h10, 8'h11, 1'b0, 4'h0);
  endtask

  task automatic test_backpressure();
    logic [7:0] r0;
    logic [3:0] f0;
    int w;
    bus.op = 4'h0; bus.a = 8'h7F; bus.b = 8'h01; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.op = 4'h9; bus.a = 8'hAA; bus.b = 8'h55; bus.flags_wr = 1'b1; bus.flags_in = 4'hF;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    r0 = bus.result; f0 = bus.flags;
    checks++;
    if (r0 !== 8'h80 || f0 !== 4'b1000) begin
      errors++; $display("FAIL bp first: got res %h flg %b exp 80 1000", r0, f0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.result !== r0 || bus.flags !== f0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp hold %0d: got res %h flg %b rdy %b vld %b exp %h %b 0 1",
                 i, bus.result, bus.flags, bus.in_ready, bus.out_valid, r0, f0);
      end
    end
    bus.in_valid = 1'b0; bus.flags_wr = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp release: got rdy %b vld %b exp 1 0", bus.in_ready, bus.out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.flags !== f0) begin
      errors++; $display("FAIL bp no stray accept: got vld %b flg %b exp 0 %b", bus.out_valid, bus.flags, f0);
    end
    tb_flags = f0;
  endtask

  task automatic test_reset_mid_shift();
    run_op("pre", 4'h0, 8'hFF, 8'h01, 1'b0, 4'h0);
    bus.op = 4'hA; bus.a = 8'h96; bus.b = 8'h07; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid shift busy: got rdy %b vld %b exp 0 0", bus.in_ready, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.flags !== 4'h0 || bus.result !== 8'h00 ||
        bus.in_ready !== 1'b1 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: got vld %b flg %b res %h rdy %b err %b exp 0 0000 00 1 0",
               bus.out_valid, bus.flags, bus.result, bus.in_ready, bus.out_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_flags = 4'h0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL after reset: got vld %b rdy %b exp 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_mul();
    run_op("mul", 4'h5, 8'h10, 8'h11, 1'b0, 4'h0);
    run_op("mul_ff", 4'h5, 8'hFF, 8'hFF, 1'b0, 4'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0), 4'($urandom));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 4'h0; bus.a = 8'h00; bus.b = 8'h00;
    bus.flags_wr = 1'b0; bus.flags_in = 4'h0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_arith();
    test_shift();
    test_illegal();
    test_backpressure();
    test_reset_mid_shift();
    test_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
